// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter slice.
//   arb_state_e          : arbiter FSM state (IDLE / GRANT)
//   ARB_DEFAULT_N        : default number of requesters
//   ARB_DEFAULT_MAX_HOLD : default hold limit (0 = unlimited)
//   onehot_to_idx        : index of the lowest set bit of a vector up to 16
//                          bits wide; returns 0 for an all-zero vector
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_DEFAULT_N        = 4;
    localparam int ARB_DEFAULT_MAX_HOLD = 8;

    // Scan from the top down so the lowest set bit is the one that is kept.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] vec);
        logic [3:0] result;
        result = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                result = 4'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin search: returns the first set bit of mask,
// searching upward from ptr and wrapping from N-1 back to 0.
// Ports:
//   mask  [N-1:0]          candidate requesters
//   ptr   [$clog2(N)-1:0]  starting position of the search (must be < N)
//   found                  at least one mask bit is set
//   idx   [$clog2(N)-1:0]  winning index (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_DEFAULT_N
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Walk the offsets from farthest to nearest so the nearest hit after ptr
    // overwrites the others. The wrap is done by subtraction so N need not
    // be a power of two.
    always_comb begin
        int pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (mask[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// rr_arbiter_ctrl
// Registered round-robin arbiter sharing one resource among N requesters.
// A grant is held while its owner keeps requesting; after MAX_HOLD
// consecutive cycles it is rotated to the next waiting requester.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   request      [N-1:0] level-sensitive request per requester
//   grant        [N-1:0] one-hot grant (registered)
//   grant_valid  |grant (registered)
//   grant_id     [$clog2(N)-1:0] index of granted requester, 0 when idle
//   preempt      one-cycle pulse accompanying a forced rotation
// ---------------------------------------------------------------------------
module rr_arbiter_ctrl
    import arb_pkg::*;
#(
    parameter int N        = ARB_DEFAULT_N,
    parameter int MAX_HOLD = ARB_DEFAULT_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 preempt
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;

    logic [N-1:0]  cand_mask;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] next_ptr;
    logic          owner_req;
    logic          at_limit;

    // grant is zero in IDLE, so one mask serves both states: in GRANT it
    // removes the current owner from the candidates.
    assign cand_mask   = request & ~grant;
    assign pick_onehot = N'(1) << pick_idx;
    assign next_ptr    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
    assign owner_req   = request[grant_id];
    assign at_limit    = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIMIT);

    rr_priority_pick #(
        .N (N)
    ) u_pick (
        .mask  (cand_mask),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Arbiter FSM with registered outputs. preempt defaults low every cycle
    // so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            preempt     <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant       <= pick_onehot;
                        grant_valid <= 1'b1;
                        grant_id    <= pick_idx;
                        ptr         <= next_ptr;
                        hold_cnt    <= HW'(1);
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        if (pick_found) begin
                            grant    <= pick_onehot;
                            grant_id <= pick_idx;
                            ptr      <= next_ptr;
                            hold_cnt <= HW'(1);
                        end else begin
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                            hold_cnt    <= '0;
                            state       <= IDLE;
                        end
                    end else if (!at_limit) begin
                        if (MAX_HOLD != 0) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (pick_found) begin
                        grant    <= pick_onehot;
                        grant_id <= pick_idx;
                        ptr      <= next_ptr;
                        hold_cnt <= HW'(1);
                        preempt  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_ctrl
// Directed self-checking bench for rr_arbiter_ctrl with N=4, MAX_HOLD=4.
// Inputs are driven on the falling edge and outputs are sampled on the
// following falling edge, one rising edge later.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_ctrl;
    import arb_pkg::*;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] request;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         preempt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         do_reset;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic       exp_preempt;
        string      name;
    } vec_t;

    vec_t vecs[7];

    rr_arbiter_ctrl #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare every output against values derived from the expected grant
    task automatic checkOutput(input string name, input logic [3:0] exp_grant,
                               input logic exp_preempt);
        logic [3:0] idx4;
        logic       exp_valid;
        idx4      = onehot_to_idx({12'b0, exp_grant});
        exp_valid = |exp_grant;
        checks++;
        if ({grant, grant_valid, grant_id, preempt} !==
            {exp_grant, exp_valid, idx4[1:0], exp_preempt}) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%b valid=%b id=%0d preempt=%b, required grant=%b valid=%b id=%0d preempt=%b",
                     name, grant, grant_valid, grant_id, preempt,
                     exp_grant, exp_valid, idx4[1:0], exp_preempt);
        end
    endtask

    // Drive a request pattern on a falling edge and advance one rising edge
    task automatic applyStimulus(input logic [3:0] req);
        request = req;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Async reset pulse between edges; outputs are checked while held
    task automatic doReset();
        @(negedge clk);
        request = '0;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_values", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        request = '0;

        // Single request, handoff and pointer retention
        vecs[0] = '{1'b1, 4'b0001, 4'b0001, 1'b0, "single_first"};
        vecs[1] = '{1'b0, 4'b0001, 4'b0001, 1'b0, "single_hold1"};
        vecs[2] = '{1'b0, 4'b0001, 4'b0001, 1'b0, "single_hold2"};
        vecs[3] = '{1'b1, 4'b0101, 4'b0001, 1'b0, "handoff_first"};
        vecs[4] = '{1'b0, 4'b0100, 4'b0100, 1'b0, "handoff_switch"};
        vecs[5] = '{1'b0, 4'b0000, 4'b0000, 1'b0, "ptr_ret_idle"};
        vecs[6] = '{1'b0, 4'b0101, 4'b0001, 1'b0, "ptr_ret_wrap"};

        #3;
        checkOutput("reset_at_start", 4'b0000, 1'b0);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].do_reset) begin
                doReset();
            end
            applyStimulus(vecs[v].req);
            checkOutput(vecs[v].name, vecs[v].exp_grant, vecs[v].exp_preempt);
        end

        // Rotation under full load: MAX_HOLD cycles each, in index order
        doReset();
        for (int c = 0; c < 17; c++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << ((c / MAX_HOLD) % N);
            applyStimulus(4'b1111);
            checkOutput($sformatf("rotation_c%0d", c), exp_g,
                        (c > 0) && (c % MAX_HOLD == 0));
        end

        // Sole holder keeps the grant past the limit without preemption
        doReset();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b0010);
            checkOutput($sformatf("sole_c%0d", c), 4'b0010, 1'b0);
        end

        // Async reset mid-grant: advance to owner 1 so ptr is non-zero first
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b1111);
        end
        checkOutput("async_pre", 4'b0010, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_drop", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1111);
        checkOutput("async_after", 4'b0001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_ctrl.md
Name: rr_arbiter_ctrl

Overview:
- Registered round-robin arbiter that shares one resource between N requesters; it is the next-generation controller behind arbiter_interface.
- Grants are one-hot and held while the winner keeps requesting.
- A hold limit forces rotation when other requesters are waiting, so no requester can starve the rest.
- Sits between requester agents and the shared resource; all outputs are registered.

Parameters:
- N, 4, number of requesters; legal values are 2 to 16.
- MAX_HOLD, 8, maximum consecutive grant cycles while others are pending; 0 means no limit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- request  input  N  one bit per requester, level-sensitive.
- grant  output  N  one-hot grant, registered.
- grant_valid  output  1  equals |grant, registered.
- grant_id  output  $clog2(N)  index of the granted requester; 0 when idle.
- preempt  output  1  one-cycle pulse on the edge where a grant is forcibly rotated.

Behaviour:
- Reset (async, rst_n=0): grant=0, grant_valid=0, grant_id=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0. A mid-grant reset drops grant immediately, without waiting for a clock edge.
- Latency: request is sampled at a posedge, and grant is visible after that same edge. Request driven at edge k appears as grant after edge k+1 when driven non-blocking from the bench.
- Pick function: first set bit of a candidate mask, searching upward from ptr and wrapping N-1 -> 0.
- On every new grant:
  - ptr <= (winner+1) mod N
  - hold_cnt <= 1
  - grant_id <= winner
- State IDLE:
  - request==0: stay IDLE, grant=0.
  - Otherwise pick from request, go to GRANT.
- State GRANT (winner w):
  - Release: request[w]==0 and others pending -> pick from request with bit w masked, same edge, no idle bubble; preempt=0.
  - Release: request[w]==0 and none pending -> IDLE, grant=0 next edge; ptr is kept.
  - Hold: request[w]==1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD) -> keep grant; hold_cnt increments, saturating at MAX_HOLD.
  - Preempt: request[w]==1, hold_cnt==MAX_HOLD and other bits pending -> pick from request with w masked; preempt=1 for one cycle.
  - Sole requester at the limit: request[w]==1, hold_cnt==MAX_HOLD, no others -> keep grant; preempt=0; hold_cnt stays saturated.
- Fairness: with all N requesting continuously, each requester gets exactly MAX_HOLD cycles in index order.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits, minimum 1.
  - ptr and grant_id are $clog2(N) bits.
  - Modulo wrap must be explicit for N that is not a power of two.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - A grant is never given to a requester whose request bit was 0 at the sampling edge.
- Request changes between edges are ignored.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_e
  - localparams ARB_DEFAULT_N=4 and ARB_DEFAULT_MAX_HOLD=8
  - function onehot_to_idx, shared with the bench for checking.
- One combinational sub-module, rr_priority_pick (parameter N; inputs mask[N-1:0] and ptr; outputs found and idx), instantiated once.
- The FSM, counters and output registers stay in rr_arbiter_ctrl.

Test Plan:
All scenarios use N=4, MAX_HOLD=4.
- Single request: after reset, drive request=0001 at edge 1. Required: grant=0001, grant_id=0 after edge 2; still 0001 two edges later; preempt stays 0.
- Handoff: request=0101 from IDLE with ptr=0. Required: grant=0001. Drop bit 0 -> grant=0100 after the next edge, with no cycle of grant=0.
- Rotation under load: request=1111 held constant. Required sequence is 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001, with preempt pulsing once at each switch.
- Sole holder: request=0010 held for 10 cycles. Required: grant=0010 throughout, preempt never asserts.
- Async reset: assert rst_n=0 mid-grant, between edges. Required: grant=0 and grant_valid=0 without a clock edge. After release, request=1111 -> grant=0001 (ptr was reset).
- Pointer retention: grant 0100 released with no other requests -> IDLE, grant=0. Then request=0101 -> grant=0001 (ptr=3 wraps to 0).
